// File: rtl/flit_link_pkg.sv
// ============================================================================
// flit_link_pkg : shared link-layer types and opcode constants
// Rev 1.0
// ============================================================================
`default_nettype none

package flit_link_pkg;

  typedef enum logic [1:0] {
    ST_STOP       = 2'd0,
    ST_ACTIVATE   = 2'd1,
    ST_RUN        = 2'd2,
    ST_DEACTIVATE = 2'd3
  } link_state_e;

  localparam int                c_opc_lsb        = 0;
  localparam int                c_opc_w          = 4;
  localparam logic [c_opc_w-1:0] c_opc_lcrdreturn = 4'h0;

endpackage

`default_nettype wire

// File: rtl/link_crd_cnt.sv
// ============================================================================
// link_crd_cnt : saturating up/down link credit counter with sticky overflow
// Rev 1.0
// ============================================================================
`default_nettype none

module link_crd_cnt #(
  parameter int MAX_CREDIT = 15,
  parameter int CRD_W      = $clog2(MAX_CREDIT + 1)
) (
  input  logic             clock,
  input  logic             rstn,
  input  logic             i_inc,
  input  logic             i_dec,
  input  logic             i_ovf_set,
  output logic [CRD_W-1:0] o_cnt,
  output logic             o_ovf
);

  localparam logic [CRD_W-1:0] c_max = CRD_W'(MAX_CREDIT);

  logic [CRD_W-1:0] r_cnt;
  logic             r_ovf;
  logic             w_full;
  logic             w_sat;

  assign w_full = (r_cnt == c_max);
  // A grant paired with a send is a net zero and never overflows
  assign w_sat  = i_inc & ~i_dec & w_full;

  always_ff @(posedge clock) begin
    if (!rstn) begin
      r_cnt <= '0;
      r_ovf <= 1'b0;
    end else begin
      if (i_inc && !i_dec && !w_full) begin
        r_cnt <= r_cnt + CRD_W'(1);
      end else if (i_dec && !i_inc && (r_cnt != '0)) begin
        r_cnt <= r_cnt - CRD_W'(1);
      end
      if (w_sat || i_ovf_set) begin
        r_ovf <= 1'b1;
      end
    end
  end

  assign o_cnt = r_cnt;
  assign o_ovf = r_ovf;

endmodule

`default_nettype wire

// File: rtl/flit_link_tx.sv
// ============================================================================
// flit_link_tx : credit-gated flit link transmitter with activation handshake
// Rev 1.0
// ============================================================================
`default_nettype none

module flit_link_tx
  import flit_link_pkg::*;
#(
  parameter int FLIT_WIDTH = 128,
  parameter int MAX_CREDIT = 15,
  parameter int CRD_W      = $clog2(MAX_CREDIT + 1)
) (
  input  logic                  clock,
  input  logic                  rstn,
  input  logic                  link_en,
  input  logic                  fifo_nempty,
  input  logic [FLIT_WIDTH-1:0] fifo_dout,
  output logic                  fifo_pop,
  output logic                  txlinkactivereq,
  input  logic                  txlinkactiveack,
  output logic                  txflitpend,
  output logic                  txflitv,
  output logic [FLIT_WIDTH-1:0] txflit,
  input  logic                  rxlcrdv,
  output logic [CRD_W-1:0]      crd_cnt,
  output logic                  crd_ovf
);

  link_state_e           r_state;
  link_state_e           w_state_next;
  logic                  r_req;
  logic                  r_pend;
  logic                  r_flitv;
  logic [FLIT_WIDTH-1:0] r_flit;
  logic [FLIT_WIDTH-1:0] w_ret_flit;
  logic [CRD_W-1:0]      w_crd;
  logic                  w_has_crd;
  logic                  w_pop;
  logic                  w_ret;
  logic                  w_send;
  logic                  w_grant;
  logic                  w_stop_grant;
  logic                  w_req_d;
  logic                  w_pend_d;

  assign w_has_crd = (w_crd != '0);

  always_ff @(posedge clock) begin
    if (!rstn) begin
      r_state <= ST_STOP;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_STOP: begin
        if (link_en) w_state_next = ST_ACTIVATE;
      end
      ST_ACTIVATE: begin
        if (!link_en) w_state_next = ST_DEACTIVATE;
        else if (txlinkactiveack) w_state_next = ST_RUN;
      end
      ST_RUN: begin
        if (!link_en) w_state_next = ST_DEACTIVATE;
      end
      ST_DEACTIVATE: begin
        if (!w_has_crd && !txlinkactiveack) w_state_next = ST_STOP;
      end
      default: w_state_next = ST_STOP;
    endcase
  end

  // Send decisions look only at the registered count, never at this cycle's grant
  always_comb begin
    w_pop        = rstn & (r_state == ST_RUN) & fifo_nempty & w_has_crd;
    w_ret        = rstn & (r_state == ST_DEACTIVATE) & w_has_crd;
    w_send       = w_pop | w_ret;
    w_grant      = rxlcrdv & (r_state != ST_STOP);
    w_stop_grant = rxlcrdv & (r_state == ST_STOP);
    w_req_d      = (w_state_next == ST_ACTIVATE) | (w_state_next == ST_RUN);
    w_pend_d     = (w_state_next == ST_RUN) | (w_state_next == ST_DEACTIVATE);
  end

  always_comb begin
    w_ret_flit = '0;
    w_ret_flit[c_opc_lsb +: c_opc_w] = c_opc_lcrdreturn;
  end

  always_ff @(posedge clock) begin
    if (!rstn) begin
      r_req   <= 1'b0;
      r_pend  <= 1'b0;
      r_flitv <= 1'b0;
      r_flit  <= '0;
    end else begin
      r_req   <= w_req_d;
      r_pend  <= w_pend_d;
      r_flitv <= w_send;
      if (w_pop) begin
        r_flit <= fifo_dout;
      end else if (w_ret) begin
        r_flit <= w_ret_flit;
      end
    end
  end

  link_crd_cnt #(
    .MAX_CREDIT (MAX_CREDIT),
    .CRD_W      (CRD_W)
  ) u_crd (
    .clock     (clock),
    .rstn      (rstn),
    .i_inc     (w_grant),
    .i_dec     (w_send),
    .i_ovf_set (w_stop_grant),
    .o_cnt     (w_crd),
    .o_ovf     (crd_ovf)
  );

  assign crd_cnt         = w_crd;
  assign fifo_pop        = w_pop;
  assign txlinkactivereq = r_req;
  assign txflitpend      = r_pend;
  assign txflitv         = r_flitv;
  assign txflit          = r_flit;

endmodule

`default_nettype wire

// File: tb/tb_flit_link_tx.sv
// ============================================================================
// tb_flit_link_tx : directed + randomized bench for flit_link_tx
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_flit_link_tx;

  localparam int FW   = 128;
  localparam int MAXC = 15;
  localparam int CW   = $clog2(MAXC + 1);

  localparam int P_STOP  = 0;
  localparam int P_ACT   = 1;
  localparam int P_RUN   = 2;
  localparam int P_DEACT = 3;

  logic          clock = 1'b0;
  logic          rstn = 1'b0;
  logic          link_en = 1'b0;
  logic          fifo_nempty = 1'b0;
  logic [FW-1:0] fifo_dout = '0;
  logic          fifo_pop;
  logic          txlinkactivereq;
  logic          txlinkactiveack = 1'b0;
  logic          txflitpend;
  logic          txflitv;
  logic [FW-1:0] txflit;
  logic          rxlcrdv = 1'b0;
  logic [CW-1:0] crd_cnt;
  logic          crd_ovf;

  int n_total = 0;
  int n_bad   = 0;

  // Reference model: link phase, integer credit balance, upstream FIFO as a queue
  logic [FW-1:0] fifo_q[$];
  int            m_phase = P_STOP;
  int            m_crd   = 0;
  logic          m_ovf   = 1'b0;
  logic          m_flitv = 1'b0;
  logic [FW-1:0] m_flit  = '0;

  always #5 clock = ~clock;

  flit_link_tx #(
    .FLIT_WIDTH (FW),
    .MAX_CREDIT (MAXC),
    .CRD_W      (CW)
  ) dut (
    .clock           (clock),
    .rstn            (rstn),
    .link_en         (link_en),
    .fifo_nempty     (fifo_nempty),
    .fifo_dout       (fifo_dout),
    .fifo_pop        (fifo_pop),
    .txlinkactivereq (txlinkactivereq),
    .txlinkactiveack (txlinkactiveack),
    .txflitpend      (txflitpend),
    .txflitv         (txflitv),
    .txflit          (txflit),
    .rxlcrdv         (rxlcrdv),
    .crd_cnt         (crd_cnt),
    .crd_ovf         (crd_ovf)
  );

  task automatic check_val(input string tag, input logic [FW-1:0] obs, input logic [FW-1:0] exp);
    n_total++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [FW-1:0] rand_flit();
    logic [FW-1:0] f;
    f = {$urandom(), $urandom(), $urandom(), $urandom()};
    if (f[3:0] == 4'h0) f[3:0] = 4'h1;
    return f;
  endfunction

  task automatic push_flits(input int n);
    for (int i = 0; i < n; i++) fifo_q.push_back(rand_flit());
  endtask

  // One clock cycle: drive, check the pop decision, advance model, check outputs
  task automatic step(input logic r, input logic le, input logic ak, input logic rx);
    logic exp_pop;
    logic exp_ret;
    int   grant;
    int   sent;
    int   nxt;
    @(negedge clock);
    rstn            = r;
    link_en         = le;
    txlinkactiveack = ak;
    rxlcrdv         = rx;
    fifo_nempty     = (fifo_q.size() > 0);
    fifo_dout       = (fifo_q.size() > 0) ? fifo_q[0] : rand_flit();
    #1;
    exp_pop = r && (m_phase == P_RUN) && (fifo_q.size() > 0) && (m_crd > 0);
    exp_ret = r && (m_phase == P_DEACT) && (m_crd > 0);
    check_val("fifo_pop", FW'(fifo_pop), FW'(exp_pop));

    if (!r) begin
      m_phase = P_STOP;
      m_crd   = 0;
      m_ovf   = 1'b0;
      m_flitv = 1'b0;
      m_flit  = '0;
    end else begin
      if (exp_pop) begin
        m_flit = fifo_q.pop_front();
      end else if (exp_ret) begin
        m_flit = '0;
      end
      m_flitv = exp_pop || exp_ret;
      sent    = (exp_pop || exp_ret) ? 1 : 0;
      grant   = (rx && m_phase != P_STOP) ? 1 : 0;
      if (rx && m_phase == P_STOP) m_ovf = 1'b1;
      case (m_phase)
        P_STOP:  if (le) m_phase = P_ACT;
        P_ACT:   if (!le) m_phase = P_DEACT; else if (ak) m_phase = P_RUN;
        P_RUN:   if (!le) m_phase = P_DEACT;
        default: if (m_crd == 0 && !ak) m_phase = P_STOP;
      endcase
      nxt = m_crd + grant - sent;
      if (nxt > MAXC) begin
        nxt   = MAXC;
        m_ovf = 1'b1;
      end
      m_crd = nxt;
    end

    @(posedge clock);
    #1;
    check_val("txflitv", FW'(txflitv), FW'(m_flitv));
    check_val("txflit", txflit, m_flit);
    check_val("crd_cnt", FW'(crd_cnt), FW'(m_crd));
    check_val("crd_ovf", FW'(crd_ovf), FW'(m_ovf));
    check_val("txlinkactivereq", FW'(txlinkactivereq), FW'(m_phase == P_ACT || m_phase == P_RUN));
    check_val("txflitpend", FW'(txflitpend), FW'(m_phase == P_RUN || m_phase == P_DEACT));
  endtask

  initial begin
    int   n_ret;
    logic le;
    logic ak;
    logic rx;
    logic r;

    // Reset and activation
    step(1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b0);
    check_val("rst_crd", FW'(crd_cnt), '0);
    check_val("rst_flitv", FW'(txflitv), '0);
    step(1'b1, 1'b1, 1'b0, 1'b0);
    check_val("act_req", FW'(txlinkactivereq), FW'(1));
    step(1'b1, 1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b1, 1'b0);
    check_val("run_pend", FW'(txflitpend), FW'(1));

    // Credit-gated send of A, B, C
    push_flits(3);
    step(1'b1, 1'b1, 1'b1, 1'b1);
    step(1'b1, 1'b1, 1'b1, 1'b1);
    step(1'b1, 1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 1'b1, 1'b0);
    check_val("c_held", FW'(fifo_q.size()), FW'(1));
    step(1'b1, 1'b1, 1'b1, 1'b1);
    step(1'b1, 1'b1, 1'b1, 1'b0);
    check_val("c_sent_crd", FW'(crd_cnt), '0);

    // Back-to-back grant and send at one credit
    push_flits(8);
    step(1'b1, 1'b1, 1'b1, 1'b1);
    for (int i = 0; i < 8; i++) step(1'b1, 1'b1, 1'b1, 1'b1);
    check_val("b2b_crd", FW'(crd_cnt), FW'(1));
    check_val("b2b_drained", FW'(fifo_q.size()), '0);

    // Deactivate holding three credits with a nonempty FIFO
    step(1'b1, 1'b1, 1'b1, 1'b1);
    step(1'b1, 1'b1, 1'b1, 1'b1);
    step(1'b1, 1'b0, 1'b1, 1'b0);
    push_flits(4);
    n_ret = 0;
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 1'b0, 1'b1, 1'b0);
      if (txflitv && txflit == '0) n_ret++;
    end
    check_val("ret_count", FW'(n_ret), FW'(3));
    step(1'b1, 1'b0, 1'b0, 1'b0);
    check_val("deact_stop_pend", FW'(txflitpend), '0);
    fifo_q.delete();

    // Overflow: sixteen grants with nothing to send
    step(1'b1, 1'b1, 1'b1, 1'b0);
    step(1'b1, 1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 16; i++) step(1'b1, 1'b1, 1'b1, 1'b1);
    check_val("ovf_crd", FW'(crd_cnt), FW'(MAXC));
    check_val("ovf_flag", FW'(crd_ovf), FW'(1));
    step(1'b1, 1'b1, 1'b1, 1'b0);
    check_val("ovf_sticky", FW'(crd_ovf), FW'(1));

    // Reset mid-RUN with five credits and a flit in flight
    step(1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b1, 1'b0);
    step(1'b1, 1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 6; i++) step(1'b1, 1'b1, 1'b1, 1'b1);
    push_flits(1);
    step(1'b1, 1'b1, 1'b1, 1'b0);
    check_val("inflight_crd", FW'(crd_cnt), FW'(5));
    step(1'b0, 1'b1, 1'b1, 1'b0);
    check_val("midrst_crd", FW'(crd_cnt), '0);
    check_val("midrst_flitv", FW'(txflitv), '0);
    check_val("midrst_flit", txflit, '0);
    step(1'b1, 1'b0, 1'b0, 1'b0);
    check_val("midrst_noret", FW'(txflitv), '0);

    // Randomized traffic
    le = 1'b1;
    for (int i = 0; i < 800; i++) begin
      if ($urandom_range(0, 24) == 0) le = ~le;
      r  = ($urandom_range(0, 199) != 0);
      ak = ($urandom_range(0, 4) == 0) ? logic'($urandom_range(0, 1))
                                       : logic'(m_phase == P_ACT || m_phase == P_RUN);
      rx = ($urandom_range(0, 2) == 0) && ((m_crd < MAXC) || ($urandom_range(0, 7) == 0));
      if (fifo_q.size() < 4 && $urandom_range(0, 1) == 1) push_flits(1);
      step(r, le, ak, rx);
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
